// File: rtl/sdram_pro_arbit_pkg.sv
// Shared SDRAM command encodings, idle bus values and arbiter state encoding
// for the sdram_pro arbiter and anything that monitors it.
package sdram_pro_arbit_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] NO_OPERATION = 4'b0111;
    localparam logic [3:0] PRECHARGE    = 4'b0010;
    localparam logic [3:0] AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] ACTIVE       = 4'b0011;
    localparam logic [3:0] WRITE        = 4'b0100;
    localparam logic [3:0] READ         = 4'b0101;
    localparam logic [3:0] LOAD_MODE    = 4'b0000;

    localparam logic [1:0]  IDLE_BANK = 2'b11;
    localparam logic [11:0] IDLE_ADDR = 12'hfff;

    typedef enum logic [2:0] {
        ARB_INIT  = 3'd0,
        ARB_ARBIT = 3'd1,
        ARB_ATREF = 3'd2,
        ARB_WRITE = 3'd3,
        ARB_READ  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [11:0] addr;
    } sdram_bus_t;

    function automatic sdram_bus_t idle_bus();
        sdram_bus_t b;
        b.cmd  = NO_OPERATION;
        b.bank = IDLE_BANK;
        b.addr = IDLE_ADDR;
        return b;
    endfunction

endpackage

// File: rtl/sdram_pro_arbit.sv
// SDRAM bus arbiter: init owns the bus until init_end, then refresh > write/read
// with optional write/read round-robin and a per-grant watchdog.
module sdram_pro_arbit
    import sdram_pro_arbit_pkg::*;
#(
    parameter int OWN_TIMEOUT  = 1023,
    parameter bit RW_ALTERNATE = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_bank,
    input  logic [11:0] init_addr,
    input  logic        atref_req,
    input  logic        atref_end,
    input  logic [3:0]  atref_cmd,
    input  logic [1:0]  atref_bank,
    input  logic [11:0] atref_addr,
    output logic        atref_en,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank,
    input  logic [11:0] wr_addr,
    output logic        wr_en,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank,
    input  logic [11:0] rd_addr,
    output logic        rd_en,
    output logic        atref_pend,
    output logic        arb_timeout,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_bank,
    output logic [11:0] sdram_addr
);

    arb_state_t  state;
    logic [9:0]  own_cnt;
    logic        last_wr;
    logic        own_end;
    logic        own_tmo;
    logic        pick_wr;

    always_comb begin
        own_end = 1'b0;
        case (state)
            ARB_ATREF: own_end = atref_end;
            ARB_WRITE: own_end = wr_end;
            ARB_READ:  own_end = rd_end;
            default:   own_end = 1'b0;
        endcase
    end

    assign own_tmo = (own_cnt == 10'(OWN_TIMEOUT - 1));
    // On a write/read tie, alternate away from the last served side.
    assign pick_wr = wr_req && (!rd_req || !RW_ALTERNATE || !last_wr);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ARB_INIT;
            atref_en    <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            atref_pend  <= 1'b0;
            arb_timeout <= 1'b0;
            own_cnt     <= '0;
            last_wr     <= 1'b0;
        end else begin
            atref_en    <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            arb_timeout <= 1'b0;
            atref_pend  <= atref_req && (state == ARB_WRITE || state == ARB_READ);
            case (state)
                ARB_INIT: begin
                    if (init_end) state <= ARB_ARBIT;
                end
                ARB_ARBIT: begin
                    own_cnt <= '0;
                    if (atref_req) begin
                        state    <= ARB_ATREF;
                        atref_en <= 1'b1;
                    end else if (pick_wr) begin
                        state   <= ARB_WRITE;
                        wr_en   <= 1'b1;
                        last_wr <= 1'b1;
                    end else if (rd_req) begin
                        state   <= ARB_READ;
                        rd_en   <= 1'b1;
                        last_wr <= 1'b0;
                    end
                end
                ARB_ATREF, ARB_WRITE, ARB_READ: begin
                    // A late end on the watchdog edge still counts as a clean end.
                    if (own_end) begin
                        state <= ARB_ARBIT;
                    end else if (own_tmo) begin
                        state       <= ARB_ARBIT;
                        arb_timeout <= 1'b1;
                    end else begin
                        own_cnt <= own_cnt + 10'd1;
                    end
                end
                default: state <= ARB_INIT;
            endcase
        end
    end

    always_comb begin
        sdram_cmd  = NO_OPERATION;
        sdram_bank = IDLE_BANK;
        sdram_addr = IDLE_ADDR;
        case (state)
            ARB_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            ARB_ATREF: begin
                sdram_cmd  = atref_cmd;
                sdram_bank = atref_bank;
                sdram_addr = atref_addr;
            end
            ARB_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            ARB_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = NO_OPERATION;
                sdram_bank = IDLE_BANK;
                sdram_addr = IDLE_ADDR;
            end
        endcase
    end

endmodule

// File: doc/sdram_pro_arbit.md
Name: sdram_pro_arbit

Overview:
- Owns the single SDRAM command/bank/address bus.
- Holds the bus for the init sequencer until init_end, then grants it to one of three requesters: auto-refresh, write, read.
- Grants by fixed priority, with round-robin between write and read.
- Sits in the sdram_pro top between the init, auto-refresh, write and read modules and the SDRAM pins.
- Includes a per-grant watchdog so a hung owner cannot lock the bus.

Parameters:
- OWN_TIMEOUT, 1023: maximum cycles a grant may be held before it is forcibly revoked; counter width is 10 bits.
- RW_ALTERNATE, 1: 1 = write/read round-robin when both are pending; 0 = write always beats read.

Ports:
- sys_clk  in  1  system clock (50 MHz)
- sys_rst_n  in  1  reset; see Behaviour for reset values
- init_end  in  1  init sequence complete (level, stays high)
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_bank  in  2  init bank
- init_addr  in  12  init address
- atref_req  in  1  refresh request, held until atref_end
- atref_end  in  1  refresh done, 1-cycle pulse
- atref_cmd/atref_bank/atref_addr  in  4/2/12  refresh bus
- atref_en  out  1  refresh grant pulse
- wr_req  in  1  write request, held until wr_end
- wr_end  in  1  write done pulse
- wr_cmd/wr_bank/wr_addr  in  4/2/12  write bus
- wr_en  out  1  write grant pulse
- rd_req  in  1  read request, held until rd_end
- rd_end  in  1  read done pulse
- rd_cmd/rd_bank/rd_addr  in  4/2/12  read bus
- rd_en  out  1  read grant pulse
- atref_pend  out  1  refresh pending while write/read owns the bus; owner should close its burst
- arb_timeout  out  1  1-cycle pulse when a grant is revoked by the watchdog
- sdram_cmd  out  4  muxed command to pins
- sdram_bank  out  2  muxed bank
- sdram_addr  out  12  muxed address

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk.
- Reset values: state INIT, all *_en 0, atref_pend 0, arb_timeout 0, timeout counter 0, last_rw = READ (so write wins the first tie).
- States: INIT, ARBIT, ATREF, WRITE, READ.
- INIT -> ARBIT on the first cycle init_end = 1.
- ARBIT evaluates requests in this order:
  - atref_req -> ATREF
  - else wr_req && rd_req: if RW_ALTERNATE, grant the side opposite last_rw; otherwise WRITE
  - else wr_req -> WRITE
  - else rd_req -> READ
  - else stay in ARBIT.
- Grant pulse: the matching *_en is registered and is high for exactly the first cycle in the owning state (asserted on the ARBIT -> owner clock edge). Never more than one *_en high at once.
- Owner state -> ARBIT on the edge after its own *_end is sampled high. After every grant there is at least one ARBIT cycle, so back-to-back grants are 2 cycles apart minimum.
- *_end from a non-owner is ignored. A request asserted while another requester is served is held and arbitrated in the next ARBIT cycle.
- last_rw updates on entry to WRITE or READ only.
- atref_pend = atref_req && state is WRITE or READ; registered, 1-cycle latency.
- Watchdog:
  - Counter clears on entry to any owner state and increments each owner cycle.
  - At OWN_TIMEOUT-1 without *_end: state -> ARBIT and arb_timeout pulses 1 cycle.
  - If the late *_end coincides with that edge, it is treated as a normal end and there is no timeout pulse.
- Output mux is combinational, zero latency:
  - INIT -> init_*
  - ATREF -> atref_*
  - WRITE -> wr_*
  - READ -> rd_*
  - ARBIT -> NOP (4'b0111), bank 2'b11, addr 12'hfff.
- During reset the bus therefore follows init_*, which the init module holds at NOP.
- init_end falling after INIT is ignored.
- Reset mid-grant returns to INIT immediately; grant pulses and pend flags clear.

Decomposition:
- defines.v (shared): command encodings NO_OPERATION, PRECHARGE, AUTO_REFRESH, ACTIVE, WRITE, READ, LOAD_MODE; idle bank/addr constants; arbiter state encoding ARB_INIT..ARB_READ (3 bits) for reuse by the top and the bench monitor.
- No sub-module required; the bus mux stays inline.

Test Plan:
- Hold init_cmd = PRECHARGE with init_end = 0 for 100 cycles -> sdram_cmd = PRECHARGE throughout and no *_en. Raise init_end -> next cycle sdram_cmd = 0111, bank = 3, addr = fff.
- atref_req, wr_req and rd_req all rise in the same ARBIT cycle -> atref_en pulses first. After atref_end: wr_en two cycles later. After wr_end: rd_en two cycles later.
- wr_req and rd_req held continuously with RW_ALTERNATE = 1, ends after 8 cycles each -> grants alternate W,R,W,R. With RW_ALTERNATE = 0 -> W only.
- atref_req rises during WRITE -> atref_pend high the next cycle. After wr_end -> ATREF granted before the pending rd_req.
- Write owner never pulses wr_end -> after 1023 owner cycles the state returns to ARBIT, arb_timeout pulses once, and the bus shows NOP.
- sys_rst_n low during READ -> state INIT, rd_en 0, bus = init_*. Release -> no grant until init_end.
